// File: rtl/decompressor_controller.sv
// decompressor_controller: link-to-engine frame steering and output frame regeneration from the header length.
// Optional length checking on bypass frames is built when DECOMP_LEN_CHECK_EN is defined.
module decompressor_controller #(
  parameter int BURST_WIDTH = 256,
  parameter logic [7:0] COMP_MAGIC = 8'hC5,
  parameter int CNT_W = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_en,
  input  logic in_tvalid,
  input  logic in_tlast,
  input  logic [BURST_WIDTH-1:0] in_data,
  output logic in_tready,
  input  logic full_infifo,
  output logic push_infifo,
  output logic is_header,
  output logic flag_decompression,
  input  logic empty_outfifo,
  output logic pop_outfifo,
  input  logic out_tready,
  output logic out_tvalid,
  output logic out_tlast,
  output logic [2:0] state,
  output logic len_error
);
  typedef enum logic [2:0] {IDLE = 3'd0, BYPASS = 3'd1, DECOMP = 3'd2, DRAIN = 3'd3} state_t;
  state_t st, st_nxt;
  logic [CNT_W-1:0] in_cnt, out_cnt, exp_cnt, exp_hdr;
  logic [15:0] len;
  logic [16:0] len_sum;
  logic comp, at_last, active, drain_done;
  logic unused_data;
  assign unused_data = ^in_data;
  assign state = st;
  always_comb begin
    comp = in_data[255:248] == COMP_MAGIC;
    len = comp ? {in_data[239:232], in_data[247:240]} : {in_data[135:128], in_data[143:136]};
    len_sum = {1'b0, len} + 17'd45;
    exp_hdr = CNT_W'(len_sum >> 5);
    at_last = out_cnt == exp_cnt - 1'b1;
    in_tready = ~reset & rd_en & ~full_infifo & (st != DRAIN);
    push_infifo = in_tvalid & in_tready;
    is_header = push_infifo & (st == IDLE);
    active = ~reset & ((st == BYPASS) | (st == DECOMP) | (st == DRAIN));
    // Hold back the final beat until the input side has closed the frame.
    out_tvalid = active & ~empty_outfifo & ((st == DRAIN) | ~at_last);
    pop_outfifo = out_tvalid & out_tready;
    out_tlast = out_tvalid & (st == DRAIN) & at_last;
    drain_done = pop_outfifo & out_tlast;
    st_nxt = st;
    case (st)
      IDLE:           if (push_infifo) st_nxt = in_tlast ? DRAIN : (comp ? DECOMP : BYPASS);
      BYPASS, DECOMP: if (push_infifo & in_tlast) st_nxt = DRAIN;
      DRAIN:          if (drain_done) st_nxt = IDLE;
      default:        st_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) st <= IDLE;
    else st <= st_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt <= '0;
      out_cnt <= '0;
      exp_cnt <= '0;
      flag_decompression <= 1'b0;
    end else begin
      if (is_header) begin
        in_cnt <= CNT_W'(1);
        exp_cnt <= exp_hdr;
        flag_decompression <= comp;
      end else if (push_infifo) begin
        in_cnt <= in_cnt + 1'b1;
        if (in_tlast && st == BYPASS) exp_cnt <= in_cnt + 1'b1;
      end
      if (drain_done) begin
        out_cnt <= '0;
        in_cnt <= '0;
        flag_decompression <= 1'b0;
      end else if (pop_outfifo) out_cnt <= out_cnt + 1'b1;
    end
  end
`ifdef DECOMP_LEN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) len_error <= 1'b0;
    else len_error <= push_infifo & in_tlast & (st == BYPASS) & (in_cnt + 1'b1 != exp_cnt);
  end
`else
  assign len_error = 1'b0;
`endif
endmodule

// File: tb/tb_decompressor_controller.sv
// tb_decompressor_controller: randomized frames against a frame-level reference model with an engine FIFO model.
module tb_decompressor_controller;
  localparam int W = 256;
  logic clk = 0, reset = 1, rd_en = 1, in_tvalid = 0, in_tlast = 0;
  logic full_infifo = 0, empty_outfifo = 1, out_tready = 1;
  logic [W-1:0] in_data = '0;
  logic in_tready, push_infifo, is_header, flag_decompression, pop_outfifo;
  logic out_tvalid, out_tlast, len_error;
  logic [2:0] state;

  decompressor_controller dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_data(in_data), .in_tready(in_tready), .full_infifo(full_infifo),
    .push_infifo(push_infifo), .is_header(is_header), .flag_decompression(flag_decompression),
    .empty_outfifo(empty_outfifo), .pop_outfifo(pop_outfifo), .out_tready(out_tready),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast), .state(state), .len_error(len_error)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int m_phase = 0, m_exp = 0, m_pushes = 0, m_pops = 0;
  bit m_flag = 0, m_lerr = 0, m_comp = 0;
  int avail = 0, made = 0, comp_out = 0;
  int obs_pops = 0, obs_lerr = 0, want_out = 0, frame_lerr = 0;
  int bp_mode = 0;
  bit tog = 0;

  function automatic int exp_of(int l);
    return (l + 14 + 31) / 32;
  endfunction

  function automatic int hdr_len(logic [W-1:0] d, bit c);
    return c ? int'({d[239:232], d[247:240]}) : int'({d[135:128], d[143:136]});
  endfunction

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [W-1:0] mk_hdr(bit c, logic [15:0] l);
    logic [W-1:0] d;
    d = rnd256();
    if (c) begin
      d[255:248] = 8'hC5;
      d[247:232] = {l[7:0], l[15:8]};
    end else begin
      d[255:248] = 8'h45;
      d[143:128] = {l[7:0], l[15:8]};
      d[111:96] = 16'h0008;
      d[191:184] = 8'h06;
    end
    return d;
  endfunction

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", n, a, e, $time);
    end
  endtask

  // Engine and link handshake conditions, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    empty_outfifo = (avail == 0);
    tog = !tog;
    case (bp_mode)
      1: begin full_infifo = ($urandom % 3 == 0); out_tready = ($urandom % 3 != 0); rd_en = ($urandom % 4 != 0); end
      2: begin full_infifo = tog; out_tready = !tog; rd_en = 1; end
      default: begin full_infifo = 0; out_tready = 1; rd_en = 1; end
    endcase
  end

  // Per-cycle comparison, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit e_rdy, e_push, e_hdr, e_vld, e_last, e_pop, prod;
    e_rdy = !reset && rd_en && !full_infifo && m_phase != 3;
    e_push = e_rdy && in_tvalid;
    e_hdr = e_push && m_phase == 0;
    e_vld = !reset && m_phase != 0 && avail > 0 && (m_phase == 3 || m_pops != m_exp - 1);
    e_last = e_vld && m_phase == 3 && m_pops == m_exp - 1;
    e_pop = e_vld && out_tready;
    chk("in_tready", int'(in_tready), int'(e_rdy));
    chk("push_infifo", int'(push_infifo), int'(e_push));
    chk("is_header", int'(is_header), int'(e_hdr));
    chk("out_tvalid", int'(out_tvalid), int'(e_vld));
    chk("out_tlast", int'(out_tlast), int'(e_last));
    chk("pop_outfifo", int'(pop_outfifo), int'(e_pop));
    chk("state", int'(state), m_phase);
    chk("flag_decompression", int'(flag_decompression), int'(m_flag));
    chk("len_error", int'(len_error), int'(m_lerr));
    if (pop_outfifo) obs_pops++;
    if (len_error) obs_lerr++;
    if (reset) begin
      m_phase = 0; m_exp = 0; m_pushes = 0; m_pops = 0; m_flag = 0; m_lerr = 0;
      avail = 0; made = 0; obs_pops = 0; obs_lerr = 0;
    end else begin
      prod = m_phase != 0 && made < (m_comp ? comp_out : m_pushes) && ($urandom % 4 != 0);
      if (e_pop) avail--;
      if (prod) begin avail++; made++; end
      m_lerr = 0;
      if (e_push) begin
        if (m_phase == 0) begin
          m_comp = in_data[255:248] == 8'hC5;
          m_exp = exp_of(hdr_len(in_data, m_comp));
          m_flag = m_comp;
          m_pushes = 1;
          m_phase = in_tlast ? 3 : (m_comp ? 2 : 1);
        end else begin
          m_pushes++;
          if (in_tlast) begin
            if (m_phase == 1) begin
`ifdef DECOMP_LEN_CHECK_EN
              m_lerr = m_pushes != m_exp;
`endif
              m_exp = m_pushes;
            end
            m_phase = 3;
          end
        end
      end
      if (e_pop) begin
        m_pops++;
        if (e_last) begin
          chk("frame_beats", obs_pops, want_out);
          frame_lerr = obs_lerr;
          m_phase = 0; m_pops = 0; m_pushes = 0; m_flag = 0; made = 0;
          obs_pops = 0; obs_lerr = 0;
        end
      end
    end
  end

  task automatic send_beat(logic [W-1:0] d, bit last);
    bit ok;
    ok = 0;
    in_tvalid = 1; in_data = d; in_tlast = last;
    for (int t = 0; t < 500 && !ok; t++) begin
      @(negedge clk);
      ok = in_tready;
      @(posedge clk);
      #1;
    end
    in_tvalid = 0; in_tlast = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout: beat not accepted within 500 cycles"); end
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(posedge clk);
      #1;
      done = (m_phase == 0);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL frame_timeout: frame did not complete, model phase %0d", m_phase); end
  endtask

  task automatic send_frame(bit c, int l, int n, int want);
    want_out = want;
    comp_out = c ? exp_of(l) : 0;
    send_beat(mk_hdr(c, 16'(l)), n == 1);
    for (int i = 1; i < n; i++) send_beat(rnd256(), i == n - 1);
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] h;
    int c, n, l;
    h = '0;
    h[143:128] = 16'hdc05;
    chk("pin_hdr_len", hdr_len(h, 0), 1500);
    chk("pin_exp_1500", exp_of(1500), 48);
    chk("pin_exp_0", exp_of(0), 1);
    chk("pin_exp_max", exp_of(65535), 2049);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #1;
    // Bypass 1500-byte frame
    send_frame(0, 1500, 48, 48);
    chk("bypass_len_error", frame_lerr, 0);
    // Compressed frame: output stalls one short of the end until the input closes
    want_out = 48;
    comp_out = 48;
    send_beat(mk_hdr(1, 16'd1500), 0);
    for (int i = 1; i < 9; i++) send_beat(rnd256(), 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("decomp_hold_pops", obs_pops, 47);
    chk("decomp_hold_tvalid", int'(out_tvalid), 0);
    chk("decomp_hold_state", int'(state), 2);
    chk("decomp_hold_flag", int'(flag_decompression), 1);
    @(posedge clk);
    #1;
    send_beat(rnd256(), 1);
    wait_idle();
    // Alternating backpressure
    bp_mode = 2;
    send_frame(0, 600, 20, 20);
    send_frame(1, 600, 6, 20);
    bp_mode = 0;
    // Header-only frame
    send_frame(0, 0, 1, 1);
    // Short bypass frame against a 1500-byte header
    send_frame(0, 1500, 40, 40);
`ifdef DECOMP_LEN_CHECK_EN
    chk("short_len_error", frame_lerr, 1);
`else
    chk("short_len_error", frame_lerr, 0);
`endif
    // Reset in the middle of a compressed frame
    want_out = 48;
    comp_out = 48;
    send_beat(mk_hdr(1, 16'd1500), 0);
    for (int i = 0; i < 3; i++) send_beat(rnd256(), 0);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_state", int'(state), 0);
    chk("rst_flag", int'(flag_decompression), 0);
    chk("rst_tvalid", int'(out_tvalid), 0);
    @(posedge clk);
    #1;
    send_frame(0, 200, 10, 10);
    // Randomized frames under random backpressure
    bp_mode = 1;
    for (int f = 0; f < 20; f++) begin
      c = $urandom % 2;
      n = 1 + $urandom % 12;
      l = (n == 1 && c == 0) ? $urandom % 19 : $urandom % 1501;
      send_frame(c[0], l, n, c ? exp_of(l) : (n == 1 ? exp_of(l) : n));
    end
    bp_mode = 0;
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/decompressor_controller.md
# decompressor_controller

Receive-side counterpart of the compressor controller. Accepts 256-bit stream beats from the link, recognises each frame's header beat and pushes beats into the decompression engine's input FIFO with a compressed/bypass flag. Pops the engine's output FIFO as a 256-bit stream and regenerates the original frame boundary from the header's IPv4 total length. Sits between the link receiver and the downstream consumer, one frame in flight at a time.

## Interface
Parameters:
- `BURST_WIDTH`, 256: beat width in bits; the bit positions below assume 256.
- `COMP_MAGIC`, 8'hC5: value of header bits [255:248] that marks a compressed frame.
- `CNT_W`, 12: width of the beat counters; covers the 2049-beat maximum.

Ports (clock and reset first):
- `clk` input, 1: single clock; everything is on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `rd_en` input, 1: input-side enable; when low, no new beats are accepted.
- `in_tvalid` input, 1: link beat valid.
- `in_tlast` input, 1: last beat of a link frame.
- `in_data` input, BURST_WIDTH: link beat.
- `in_tready` output, 1: beat accepted when `in_tvalid & in_tready`.
- `full_infifo` input, 1: engine input FIFO full.
- `push_infifo` output, 1: write `in_data` into the input FIFO.
- `is_header` output, 1: the beat being pushed is a header beat.
- `flag_decompression` output, 1: the current frame is compressed. Held for the whole frame.
- `empty_outfifo` input, 1: engine output FIFO empty. The FIFO is first-word-fall-through.
- `pop_outfifo` output, 1: pop the output FIFO.
- `out_tready` input, 1: downstream ready.
- `out_tvalid` output, 1: output beat valid; data comes directly from the output FIFO head.
- `out_tlast` output, 1: final beat of the regenerated frame.
- `state` output, 3: current FSM state.
- `len_error` output, 1: one-cycle length-mismatch pulse.

## Operation
- Encoding of `state`: IDLE=0, BYPASS=1, DECOMP=2, DRAIN=3. Codes 4 to 7 are illegal and return to IDLE on the next clock.
- `in_tready = rd_en & ~full_infifo & (state != DRAIN)`.
- `push_infifo = in_tvalid & in_tready`.
- `is_header = push_infifo & (state == IDLE)`.

IDLE, on an accepted beat (the header):
- The frame is compressed when `in_data[255:248] == COMP_MAGIC`.
- The length L is byte-swapped: `{in_data[135:128], in_data[143:136]}` for a bypass frame, or `{in_data[239:232], in_data[247:240]}` for a compressed frame. Example: a field of 16'hdc05 gives L = 1500.
- Expected beat count `exp = (L + 14 + 31) >> 5`, computed in 17 bits and truncated to CNT_W. Examples: L=1500 gives 48, L=0 gives 1, L=65535 gives 2049.
- `flag_decompression` is set (compressed) or cleared (bypass).
- Next state: DRAIN if `in_tlast`; otherwise DECOMP for a compressed frame or BYPASS for a bypass frame.

BYPASS / DECOMP:
- Beats are pushed and counted in `in_cnt`, which includes the header beat.
- An accepted `in_tlast` moves the FSM to DRAIN.
- In BYPASS, `exp` is overwritten with the final `in_cnt` at `in_tlast`, so bypass output always matches input.

Output side, active in BYPASS, DECOMP and DRAIN:
- `out_tvalid = ~empty_outfifo & ~(state != DRAIN & out_cnt == exp-1)`.
- `pop_outfifo = out_tvalid & out_tready`.
- `out_cnt` increments on each pop.
- `out_tlast = out_tvalid & (state == DRAIN) & (out_cnt == exp-1)`.

DRAIN:
- A pop while `out_tlast` is high moves the FSM to IDLE.
- On that transition `out_cnt`, `in_cnt` and `flag_decompression` clear.

Other rules:
- In IDLE, `out_tvalid` = 0 and `pop_outfifo` = 0 regardless of FIFO state.
- `rd_en` gates only input acceptance; output draining continues while it is low.

## Timing
- Reset values: `state`=IDLE, all counters 0, `flag_decompression`=0, `len_error`=0. Every combinational output evaluates to 0 during reset.
- `in_tready`, `push_infifo`, `is_header`, `out_tvalid`, `out_tlast` and `pop_outfifo` are combinational from current state and inputs: zero latency.
- `state`, `flag_decompression`, the counters and `exp` update on the clock edge after the accepting beat.
- The engine guarantees at least one cycle from push to output FIFO.
- Same-cycle push and pop is allowed; both counters update independently.
- Reset asserted mid-frame aborts the frame: state returns to IDLE the next cycle. The FIFOs are flushed by the same reset externally.
- A full input FIFO stalls acceptance with no loss of state.

## Configuration
- `DECOMP_LEN_CHECK_EN` defined: at an accepted `in_tlast` in BYPASS, if `in_cnt+1 != exp`, `len_error` pulses high for exactly one cycle, on the cycle after the tlast beat. `exp` is still overwritten with the actual count.
- `DECOMP_LEN_CHECK_EN` undefined: `len_error` is tied to 0 and no comparator is built. All other behaviour is identical.

## Test plan
- Bypass frame: header with [111:96]=16'h0008, [143:128]=16'hdc05, [191:184]=8'h06, then 47 more beats, tlast on beat 48. Expect `is_header` only on beat 1, `state` 0→1→3→0, exactly 48 pops, `out_tlast` only on the 48th pop, `len_error`=0.
- Compressed frame: [255:248]=8'hC5, [247:232]=16'hdc05, 10 input beats. Expect `flag_decompression`=1 from cycle 2 until DRAIN exit. Feed 48 output beats: `out_tvalid` is suppressed at `out_cnt`=47 until DRAIN, then `out_tlast` on the 48th pop.
- Backpressure: toggle `full_infifo` and `out_tready` on alternate cycles. Expect no push while full, no pop while not ready, and identical beat counts.
- Header-only frame (L=0, `in_tlast` on beat 1). Expect direct IDLE→DRAIN, 1 output beat with `out_tlast`=1, then return to IDLE.
- Bypass with L=1500 but tlast on beat 40. With the macro: `len_error` pulses once and output ends at 40 beats. Without the macro: `len_error` stays 0 and output still ends at 40 beats.
- Reset asserted mid-DECOMP. Next cycle: `state`=0, `flag_decompression`=0, `out_tvalid`=0. A following bypass frame completes normally.
